// File: rtl/add_pipe_pkg.sv
// Shared constants for the add_pipe incrementing pipeline: operating modes,
// default parameter values and the width of the handshake counter.
package add_pipe_pkg;

    // Lane overflow handling
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Default parameter values for add_pipe
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_STAGES   = 2;
    localparam int DEF_INCR     = 1;
    localparam int DEF_SATURATE = MODE_WRAP;

    // Legal number of register slices
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 8;

    // Width of the completed-output-handshake counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/add_pipe_stage.sv
// One valid/ready register slice. The slice accepts a new payload whenever it
// is empty or its downstream neighbour is taking the current one, so a full
// chain of slices can shift in a single cycle without bubbles.
module add_pipe_stage #(
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    output logic          ready,
    output logic          dn_valid,
    output logic [PW-1:0] dn_data,
    input  logic          dn_ready
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;

    assign ready    = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // Next state: load from upstream when ready; an empty upstream clears valid
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Slice registers, cleared asynchronously so outputs read zero during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/add_pipe.sv
// Multi-lane constant incrementer behind a chain of valid/ready register
// slices. The add (with optional saturation) sits in front of the first slice;
// later slices only carry the result, its per-lane carry flags and valid.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int          WIDTH    = DEF_WIDTH,
    parameter int          CHANNELS = DEF_CHANNELS,
    parameter int          STAGES   = DEF_STAGES,
    parameter int unsigned INCR     = DEF_INCR,
    parameter int          SATURATE = DEF_SATURATE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_ovf,
    output logic [CNT_W-1:0]          xfer_count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int PW = DW + CHANNELS;
    localparam logic [WIDTH:0] INCR_EXT = (WIDTH + 1)'(INCR);

    // Refuse to build with an unusable slice count or an increment that
    // does not fit in one lane
    if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "add_pipe: STAGES must be within 1..8");
    end
    if ((64'(INCR) >> WIDTH) != 64'd0) begin : g_bad_incr
        $fatal(1, "add_pipe: INCR must be below 2**WIDTH");
    end

    logic [DW-1:0]       sum_data;
    logic [CHANNELS-1:0] sum_ovf;

    // Per-lane add at WIDTH+1 bits; the carry is the lane's overflow flag
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [WIDTH:0] lane_sum;
        assign lane_sum = {1'b0, in_data[gi*WIDTH +: WIDTH]} + INCR_EXT;
        assign sum_ovf[gi] = lane_sum[WIDTH];
        assign sum_data[gi*WIDTH +: WIDTH] =
            (SATURATE == MODE_SAT && lane_sum[WIDTH]) ? {WIDTH{1'b1}} : lane_sum[WIDTH-1:0];
    end

    // Slice chain: each slice is fed by its predecessor (the adder for the
    // first one) and hears ready from its successor (out_ready for the last)
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
        logic          up_valid_w, ready_w, dn_valid_w, dn_ready_w;
        logic [PW-1:0] up_data_w, dn_data_w;

        if (gi == 0) begin : g_head
            assign up_valid_w = in_valid;
            assign up_data_w  = {sum_ovf, sum_data};
        end else begin : g_link
            assign up_valid_w = g_slice[gi-1].dn_valid_w;
            assign up_data_w  = g_slice[gi-1].dn_data_w;
        end

        if (gi == STAGES - 1) begin : g_tail
            assign dn_ready_w = out_ready;
        end else begin : g_mid
            assign dn_ready_w = g_slice[gi+1].ready_w;
        end

        add_pipe_stage #(
            .PW(PW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid_w),
            .up_data  (up_data_w),
            .ready    (ready_w),
            .dn_valid (dn_valid_w),
            .dn_data  (dn_data_w),
            .dn_ready (dn_ready_w)
        );
    end

    assign in_ready  = g_slice[0].ready_w;
    assign out_valid = g_slice[STAGES-1].dn_valid_w;
    assign out_data  = g_slice[STAGES-1].dn_data_w[DW-1:0];
    assign out_ovf   = g_slice[STAGES-1].dn_data_w[PW-1:DW];

    logic [CNT_W-1:0] xfer_q, xfer_d;

    // Count output handshakes; natural wrap at the counter width
    always_comb begin
        xfer_d = xfer_q + CNT_W'(out_valid && out_ready);
    end

    // Handshake counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign xfer_count = xfer_q;

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each channel operand.
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent lanes packed in one transfer.
REQ-003 SHALL have parameter STAGES, default 2, number of register slices (legal range 1..8).
REQ-004 SHALL have parameter INCR, default 1, unsigned constant added to every lane (WIDTH bits).
REQ-005 SHALL have parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk  input  1  single rising-edge clock.
REQ-008 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-009 SHALL have port in_valid  input  1  upstream transfer offered.
REQ-010 SHALL have port in_ready  output  1  block accepts transfer this cycle.
REQ-011 SHALL have port in_data  input  CHANNELS*WIDTH  lanes, lane k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_data  output  CHANNELS*WIDTH  incremented lanes, same packing.
REQ-015 SHALL have port out_ovf  output  CHANNELS  per-lane carry-out/saturation flag for the current result.
REQ-016 SHALL have port xfer_count  output  16  number of completed output handshakes.

Function
REQ-017 Input handshake SHALL occur when in_valid && in_ready at a rising clk edge; output handshake when out_valid && out_ready.
REQ-018 Per-lane sum SHALL be computed at WIDTH+1 bits as lane + INCR; out_ovf[k] = bit WIDTH of that sum.
REQ-019 Wrap mode SHALL output sum[WIDTH-1:0]; saturate mode SHALL output all-ones when out_ovf[k] is 1, else sum[WIDTH-1:0].
REQ-020 Addition SHALL be combinational ahead of slice 1; slices 2..STAGES only carry data, ovf and valid.
REQ-021 Each slice i SHALL hold valid_i; slice ready_i = !valid_i || ready_(i+1), with ready_(STAGES+1) = out_ready; in_ready = ready_1.
REQ-022 A slice SHALL load from its predecessor when ready_i is 1, clearing valid_i if the predecessor is empty.
REQ-023 Latency with out_ready held 1 SHALL be exactly STAGES cycles from input handshake to out_valid.
REQ-024 Throughput with out_ready held 1 SHALL be one transfer per cycle; no bubble inserted.
REQ-025 With out_ready 0 the pipeline SHALL fill and accept exactly STAGES transfers before in_ready drops to 0 (combinational from out_ready).
REQ-026 out_data/out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-027 Transfers SHALL emerge in input order, none lost or duplicated.
REQ-028 Simultaneous input and output handshake on a full pipeline SHALL shift all slices in one cycle.
REQ-029 xfer_count SHALL increment by 1 per output handshake and wrap 16'hFFFF -> 16'h0000.

Reset
REQ-030 While rst is 1 all valid bits, out_valid, out_data, out_ovf and xfer_count SHALL be 0, asynchronously.
REQ-031 Reset mid-operation SHALL discard all in-flight transfers; in_ready SHALL be 1 in the first cycle after rst deasserts (follows from all slices empty).

Structure
REQ-032 Package add_pipe_pkg SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1), default parameter values and the 16-bit counter width.
REQ-033 One sub-module add_pipe_stage (one valid/ready register slice, parametrised on payload width) SHALL be instantiated STAGES times via generate.
REQ-034 Elaboration SHALL fail (assertion) for STAGES outside 1..8 or INCR >= 2**WIDTH.

Verification (WIDTH=8, CHANNELS=2, STAGES=2, INCR=1 unless noted)
REQ-035 Lanes {8'h10,8'h20}, out_ready=1 -> out_data {8'h11,8'h21}, out_ovf 2'b00, out_valid exactly 2 cycles after handshake.
REQ-036 Wrap mode lanes {8'hFF,8'h05} -> out_data {8'h00,8'h06}, out_ovf 2'b10 (lane 1 flagged); SATURATE=1 same input -> {8'hFF,8'h06}, out_ovf 2'b10.
REQ-037 out_ready=0, stream 4 transfers -> exactly 2 accepted, in_ready=0, out_data stable; release out_ready -> all 4 emerge in order, xfer_count=4.
REQ-038 Random in_valid/out_ready, 10000 transfers, STAGES in {1,3,8} -> scoreboard order/value match, no loss.
REQ-039 rst pulse with 2 transfers in flight -> out_valid=0 and xfer_count=0 immediately; in_ready=1 next cycle; no stale output afterwards.
REQ-040 Preload 65535 handshakes -> next handshake wraps xfer_count to 0.
